// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept time and committed after a fixed busy window.
module mdu_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  hiloOp,
  input  logic [1:0]  hiloWrite,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        mdUseD,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        start,
  output logic        busy,
  output logic        stallReq
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_keep_q, pend_keep_d;

  logic        is_mul, is_div, is_signed;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, prod;
  logic        sign_a, sign_b, div_zero;
  logic [31:0] mag_a, mag_b, mag_b_safe, uq, ur, quo, rem;

  assign is_mul    = (hiloOp == 3'd1) || (hiloOp == 3'd2);
  assign is_div    = (hiloOp == 3'd3) || (hiloOp == 3'd4);
  assign is_signed = (hiloOp == 3'd1) || (hiloOp == 3'd3);

  assign prod_s = $signed(srcA) * $signed(srcB);
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};
  assign prod   = (hiloOp == 3'd1) ? prod_s : prod_u;

  // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign sign_a     = is_signed & srcA[31];
  assign sign_b     = is_signed & srcB[31];
  assign mag_a      = sign_a ? -srcA : srcA;
  assign mag_b      = sign_b ? -srcB : srcB;
  assign div_zero   = (srcB == 32'd0);
  assign mag_b_safe = div_zero ? 32'd1 : mag_b;
  assign uq         = mag_a / mag_b_safe;
  assign ur         = mag_a % mag_b_safe;
  assign quo        = (sign_a ^ sign_b) ? -uq : uq;
  assign rem        = sign_a ? -ur : ur;

  assign start    = (state_q == StIdle) && (is_mul || is_div);
  assign busy     = (state_q == StBusy);
  assign stallReq = mdUseD & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_keep_d = pend_keep_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          if (is_mul) begin
            cnt_d       = 4'd5;
            pend_hi_d   = prod[63:32];
            pend_lo_d   = prod[31:0];
            pend_keep_d = 1'b0;
          end else begin
            cnt_d       = 4'd10;
            pend_hi_d   = rem;
            pend_lo_d   = quo;
            pend_keep_d = div_zero;
          end
        end else if (hiloWrite == 2'd1) begin
          hi_d = srcA;
        end else if (hiloWrite == 2'd2) begin
          lo_d = srcA;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          if (!pend_keep_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_keep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_keep_q <= pend_keep_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: inputs change and outputs are sampled mid-cycle
// (just after the falling edge); m_hi/m_lo track the architectural HI/LO values.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic [2:0]  hiloOp;
  logic [1:0]  hiloWrite;
  logic [31:0] srcA, srcB;
  logic        mdUseD;
  logic [31:0] hi, lo;
  logic        start, busy, stallReq;

  int vecs = 0;
  int errs = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_hilo dut (
    .clk       (clk),
    .reset     (reset),
    .hiloOp    (hiloOp),
    .hiloWrite (hiloWrite),
    .srcA      (srcA),
    .srcB      (srcB),
    .mdUseD    (mdUseD),
    .hi        (hi),
    .lo        (lo),
    .start     (start),
    .busy      (busy),
    .stallReq  (stallReq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; hiloOp = 3'd1; hiloWrite = 2'd0; srcA = 32'd5; srcB = 32'd6; mdUseD = 1'b1;
    #3;
    vecs++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    vecs++;
    if (busy !== 1'b0 || start !== 1'b1 || stallReq !== 1'b1) begin
      errs++;
      $display("FAIL reset_ctrl: busy=%b start=%b stallReq=%b expected 0/1/1", busy, start, stallReq);
    end
    mdUseD = 1'b0;
    #1;
    vecs++;
    if (stallReq !== 1'b0) begin
      errs++; $display("FAIL reset_stall_nouse: stallReq=%b expected 0", stallReq);
    end
    @(negedge clk); #1;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'd0) begin
      errs++; $display("FAIL reset_held: busy=%b hi=%h expected 0/0", busy, hi);
    end
    reset = 1'b0; hiloOp = 3'd0;
    #1;
    vecs++;
    if (start !== 1'b0) begin
      errs++; $display("FAIL idle_start: start=%b expected 0", start);
    end
  endtask

  task automatic test_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input logic [31:0] eh, input logic [31:0] el,
                            input string name);
    @(negedge clk);
    hiloOp = op; srcA = a; srcB = b; hiloWrite = 2'd0; mdUseD = 1'b0;
    #1;
    vecs++;
    if (start !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL %s_accept: start=%b busy=%b expected 1/0", name, start, busy);
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      hiloOp = 3'd0; srcA = 32'hDEAD_BEEF; srcB = 32'h1234_5678;
      #1;
      vecs++;
      if (busy !== 1'b1 || start !== 1'b0 || stallReq !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errs++;
        $display("FAIL %s_busy T+%0d: busy=%b start=%b stall=%b hi=%h lo=%h expected 1/0/0 %h %h",
                 name, k, busy, start, stallReq, hi, lo, m_hi, m_lo);
      end
    end
    @(negedge clk); #1;
    vecs++;
    if (busy !== 1'b0 || hi !== eh || lo !== el) begin
      errs++;
      $display("FAIL %s_result: busy=%b hi=%h lo=%h expected 0 %h %h", name, busy, hi, lo, eh, el);
    end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_move();
    @(negedge clk);
    hiloWrite = 2'd1; srcA = 32'h11;
    @(negedge clk);
    hiloWrite = 2'd2; srcA = 32'h22;
    #1;
    vecs++;
    if (hi !== 32'h11 || lo !== m_lo) begin
      errs++; $display("FAIL mthi: hi=%h lo=%h expected 00000011 %h", hi, lo, m_lo);
    end
    @(negedge clk);
    hiloWrite = 2'd3; srcA = 32'h99;
    #1;
    vecs++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errs++; $display("FAIL mtlo: hi=%h lo=%h expected 00000011 00000022", hi, lo);
    end
    @(negedge clk);
    hiloWrite = 2'd0;
    #1;
    vecs++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errs++; $display("FAIL write3_ignored: hi=%h lo=%h expected 00000011 00000022", hi, lo);
    end
    m_hi = 32'h11; m_lo = 32'h22;
  endtask

  task automatic test_op_beats_write();
    // mult 0x11 * 0 with a simultaneous mthi: product (0) must land, not srcA.
    @(negedge clk);
    hiloOp = 3'd1; hiloWrite = 2'd1; srcA = 32'h11; srcB = 32'd0;
    @(negedge clk);
    hiloOp = 3'd0; hiloWrite = 2'd0;
    #1;
    vecs++;
    if (busy !== 1'b1 || hi !== m_hi) begin
      errs++; $display("FAIL op_beats_write_t1: busy=%b hi=%h expected 1 %h", busy, hi, m_hi);
    end
    repeat (5) @(negedge clk);
    #1;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL op_beats_write: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    hiloOp = 3'd1; srcA = 32'd2; srcB = 32'd3; mdUseD = 1'b1;
    #1;
    vecs++;
    if (start !== 1'b1 || stallReq !== 1'b1) begin
      errs++; $display("FAIL bi_accept: start=%b stallReq=%b expected 1/1", start, stallReq);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        hiloOp = 3'd1; hiloWrite = 2'd0; srcA = 32'd7; srcB = 32'd7;
      end else begin
        hiloOp = 3'd0; hiloWrite = 2'd1; srcA = 32'h55;
      end
      mdUseD = (k != 5);
      #1;
      vecs++;
      if (busy !== 1'b1 || start !== 1'b0 || stallReq !== (k != 5) || hi !== m_hi) begin
        errs++;
        $display("FAIL bi_busy T+%0d: busy=%b start=%b stall=%b hi=%h expected 1/0/%b %h",
                 k, busy, start, stallReq, (k != 5), hi, m_hi);
      end
    end
    @(negedge clk);
    hiloOp = 3'd0; hiloWrite = 2'd1; srcA = 32'h55; mdUseD = 1'b0;
    #1;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
      errs++; $display("FAIL bi_result: busy=%b hi=%h lo=%h expected 0 0 6", busy, hi, lo);
    end
    @(negedge clk);
    hiloWrite = 2'd0;
    #1;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'h55 || lo !== 32'd6) begin
      errs++; $display("FAIL bi_mthi: busy=%b hi=%h lo=%h expected 0 55 6", busy, hi, lo);
    end
    m_hi = 32'h55; m_lo = 32'd6;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    hiloOp = 3'd3; srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    hiloOp = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errs++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      vecs++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errs++;
        $display("FAIL no_commit_after_reset c%0d: busy=%b hi=%h lo=%h expected 0 0 0",
                 k, busy, hi, lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith(3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    test_arith(3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    test_arith(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    test_arith(3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, "div_negdivisor");
    test_arith(3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu");
    test_arith(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_overflow");
    test_arith(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1, "multu_max");
    test_move();
    test_arith(3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, "divu_zero");
    test_op_beats_write();
    test_busy_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
